// File: rtl/fpdiv_pkg.sv
// fpdiv_pkg: half-precision field constants, divider FSM states and a leading-zero counter
package fpdiv_pkg;
   localparam int EXP_W = 5;
   localparam int FRAC_W = 10;
   localparam int BIAS = 15;
   localparam int EXP_MAX = 31;
   localparam logic [9:0] SAT_FRAC = 10'h3FF;
   localparam int DIV_ITERS = 14;
   typedef enum logic [2:0] {IDLE, PRENORM, DIVIDE, ROUND, DONE} state_t;
   function automatic logic [3:0] lzc11(input logic [10:0] m);
      logic [3:0] n;
      n = 4'd11;
      for (int i = 0; i < 11; i++) if (m[i]) n = 4'(10 - i);
      return n;
   endfunction
endpackage

// File: rtl/mant_divider.sv
// mant_divider: restoring mantissa divider, one quotient bit per step, MSB first
module mant_divider (
   input  logic        CLK,
   input  logic        RST,
   input  logic        load,
   input  logic        step,
   input  logic [10:0] d_in,
   input  logic [10:0] r_in,
   output logic [13:0] q,
   output logic [11:0] rem
);
   logic [10:0] r_d;
   logic        w_ge;
   logic [10:0] w_diff;
   assign w_ge = rem >= {1'b0, r_d};
   // both the difference and the unrestored remainder are below d, so 11 bits suffice
   assign w_diff = w_ge ? 11'(rem - {1'b0, r_d}) : rem[10:0];
   always_ff @(posedge CLK) begin
      if (RST) begin
         q <= '0;
         rem <= '0;
         r_d <= '0;
      end else if (load) begin
         q <= '0;
         rem <= {1'b0, r_in};
         r_d <= d_in;
      end else if (step) begin
         q <= {q[12:0], w_ge};
         rem <= {w_diff, 1'b0};
      end
   end
endmodule

// File: rtl/fpdiv.sv
// fpdiv: iterative half-precision divider out = a / b with valid/ready handshakes
module fpdiv
   import fpdiv_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out,
   output logic        overflow,
   output logic        sub,
   output logic        div_zero
);
   state_t r_state, w_next;
   logic [EXP_W+FRAC_W:0] r_a, r_b;
   logic signed [7:0] r_e;
   logic [3:0] r_cnt;
   logic w_load, w_step;
   logic [13:0] w_q;
   logic [11:0] w_rem;
   logic [EXP_W-1:0] w_ea, w_eb;
   logic [FRAC_W:0] w_ma, w_mb, w_man, w_mbn;
   logic [3:0] w_lza, w_lzb;
   logic signed [7:0] w_e_pre, w_e1;
   logic [FRAC_W-1:0] w_frac0;
   logic w_g0, w_r0, w_s0, w_den, w_lost, w_s, w_rnd, w_sign;
   logic [7:0] w_sh, w_exp0, w_exp_f;
   logic [12:0] w_mant;
   logic [11:0] w_shifted, w_m;
   logic [17:0] w_sum;
   logic w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_sat, w_dz;
   logic [15:0] w_res;
   assign in_ready = r_state == IDLE;
   assign out_valid = r_state == DONE;
   assign w_sign = r_a[15] ^ r_b[15];
   assign w_ea = r_a[14:10] == '0 ? 5'd1 : r_a[14:10];
   assign w_eb = r_b[14:10] == '0 ? 5'd1 : r_b[14:10];
   assign w_ma = {r_a[14:10] != '0, r_a[FRAC_W-1:0]};
   assign w_mb = {r_b[14:10] != '0, r_b[FRAC_W-1:0]};
   assign w_lza = lzc11(w_ma);
   assign w_lzb = lzc11(w_mb);
   assign w_man = w_ma << w_lza;
   assign w_mbn = w_mb << w_lzb;
   assign w_e_pre = {3'b0, w_ea} - {4'b0, w_lza} - {3'b0, w_eb} + {4'b0, w_lzb} + 8'(BIAS);
   mant_divider u_div (
      .CLK(CLK), .RST(RST), .load(w_load), .step(w_step),
      .d_in(w_mbn), .r_in(w_man), .q(w_q), .rem(w_rem)
   );
   // quotient lies in (0.5, 2): q[13] tells whether it needs one more left shift
   assign w_e1 = w_q[13] ? r_e : r_e - 8'sd1;
   assign w_frac0 = w_q[13] ? w_q[12:3] : w_q[11:2];
   assign w_g0 = w_q[13] ? w_q[2] : w_q[1];
   assign w_r0 = w_q[13] ? w_q[1] : w_q[0];
   assign w_s0 = (w_q[13] & w_q[0]) | (|w_rem);
   assign w_den = w_e1 < 8'sd1;
   assign w_sh = 8'(8'sd1 - w_e1);
   assign w_mant = {1'b1, w_frac0, w_g0, w_r0};
   assign w_shifted = 12'(w_mant >> w_sh);
   assign w_lost = |(w_mant & ~(13'h1FFF << w_sh));
   assign w_m = w_den ? w_shifted : w_mant[11:0];
   assign w_s = w_s0 | (w_den & w_lost);
   assign w_exp0 = w_den ? 8'd0 : w_e1;
   assign w_rnd = w_m[1] & (w_m[0] | w_s);
   // a carry out of the fraction ripples straight into the exponent field
   assign w_sum = {w_exp0, w_m[11:2]} + 18'(w_rnd);
   assign w_exp_f = w_sum[17:10];
   assign w_a_inf = r_a[14:10] == 5'(EXP_MAX);
   assign w_b_inf = r_b[14:10] == 5'(EXP_MAX);
   assign w_a_zero = r_a[14:0] == '0;
   assign w_b_zero = r_b[14:0] == '0;
   assign w_sat = w_a_inf | w_b_inf | w_b_zero | (w_exp_f >= 8'(EXP_MAX));
   assign w_dz = w_b_zero & ~w_a_inf & ~w_b_inf;
   assign w_res = w_sat ? {w_sign, 5'(EXP_MAX), SAT_FRAC} :
                  w_a_zero ? {w_sign, 15'b0} : {w_sign, w_sum[14:0]};
   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_step = 1'b0;
      case (r_state)
         IDLE:    w_next = in_valid ? PRENORM : IDLE;
         PRENORM: begin
            w_load = 1'b1;
            w_next = DIVIDE;
         end
         DIVIDE:  begin
            w_step = 1'b1;
            w_next = r_cnt == 4'(DIV_ITERS - 1) ? ROUND : DIVIDE;
         end
         ROUND:   w_next = DONE;
         DONE:    w_next = out_ready ? IDLE : DONE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge CLK) r_state <= RST ? IDLE : w_next;
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_a <= '0;
         r_b <= '0;
         r_e <= '0;
         r_cnt <= '0;
         out <= '0;
         overflow <= 1'b0;
         sub <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         if (r_state == IDLE && in_valid) begin
            r_a <= a;
            r_b <= b;
         end
         if (r_state == PRENORM) begin
            r_e <= w_e_pre;
            r_cnt <= '0;
         end
         if (r_state == DIVIDE) r_cnt <= r_cnt + 4'd1;
         if (r_state == ROUND) begin
            out <= w_res;
            overflow <= w_res[14:10] == 5'(EXP_MAX);
            sub <= w_res[14:10] == '0;
            div_zero <= w_dz;
         end
      end
   end
endmodule

// File: doc/fpdiv.md
Name: fpdiv

Overview:
- Iterative IEEE-754 half-precision divider, out = a / b.
- It is the inverse-operation companion to the team's pipelined fpmul.
- It uses the same number conventions as fpmul: subnormal handling, saturating overflow encoding, and the out/overflow/sub result flags.
- Control is a valid/ready handshake on both sides. Operands pass through a prenormalize → 14-step restoring mantissa division → round/pack flow.

Parameters:
- EXP_W, 5, exponent field width. Only the default is supported.
- FRAC_W, 10, fraction field width. Only the default is supported.
- BIAS, 15, exponent bias.

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  operands a, b are valid
- in_ready  out  1  divider can accept operands
- a  in  16  dividend {sign, exp[4:0], frac[9:0]}
- b  in  16  divisor, same format
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer takes the result
- out  out  16  quotient {sign, exp, frac}
- overflow  out  1  result exponent field is 5'b11111
- sub  out  1  result exponent field is 5'b00000
- div_zero  out  1  divisor was ±0

Behaviour:
- Reset (RST=1 at a clock edge) applies from any state, including mid-divide; the in-flight operation is discarded. After reset:
  - state IDLE, in_ready=1
  - out_valid=0, out=0, overflow=0, sub=0, div_zero=0
- States and transitions:
  - IDLE: in_ready=1. On in_valid & in_ready, register a and b and go to PRENORM.
  - PRENORM (1 cycle):
    - Exponent field 0 means hidden bit 0 and effective exponent 1; otherwise hidden bit 1.
    - Left-normalize each 11-bit mantissa with a priority encoder (leading-zero count lza/lzb).
    - e = (ea_eff − lza) − (eb_eff − lzb) + BIAS, held in 8-bit signed.
    - sign = a[15] ^ b[15].
    - Load the divider with rem = ma, d = mb. Go to DIVIDE.
  - DIVIDE (exactly 14 cycles): one restoring step per cycle.
    - If rem ≥ d: q bit = 1 and rem −= d; otherwise q bit = 0.
    - Then rem <<= 1; q fills MSB-first into q[13:0].
  - ROUND (1 cycle):
    - If q[13]=1: frac = q[12:3], G = q[2], R = q[1], S = q[0] | (rem ≠ 0).
    - If q[13]=0: frac = q[11:2], G = q[1], R = q[0], S = (rem ≠ 0), and e −= 1.
    - If e ≤ 0: shift {hidden, frac, G, R} right by (1 − e), OR shifted-out bits into S, exponent field = 0. A shift ≥ 13 gives frac = 0.
    - Round up iff G & (R | S). This is the fpmul rule; ties with R=S=0 truncate.
    - A rounding carry out of frac increments the exponent; a subnormal may round up to exponent 1.
    - If the final exponent ≥ 31: out = {sign, 5'b11111, 10'h3FF}, overflow=1.
    - Special cases override the arithmetic result, checked in this priority order:
      1. a or b exponent field = 31 → saturated result, overflow=1.
      2. b = ±0 (exp=0, frac=0) → saturated result, overflow=1, div_zero=1. This includes 0/0.
      3. a = ±0 → out = {sign, 15'b0}, sub=1.
    - Register all outputs and go to DONE.
  - DONE:
    - out_valid=1, in_ready=0.
    - out and flags stay stable until out_valid & out_ready, then go to IDLE with out_valid=0 on the next cycle.
    - out and flags keep their last values until overwritten.
- Latency: fixed for all operands, including special cases. out_valid rises 16 cycles after the accepting edge.
- Throughput: one operation at a time. Back-to-back accept requires one IDLE cycle after the handshake.
- in_valid is ignored outside IDLE. a and b are sampled only on the accepting edge, so later changes have no effect.

Decomposition:
- fpdiv_pkg holds:
  - field constants EXP_W, FRAC_W, BIAS, EXP_MAX=31, SAT_FRAC=10'h3FF
  - DIV_ITERS=14
  - state enum {IDLE, PRENORM, DIVIDE, ROUND, DONE}
- One sub-module, mant_divider: restoring divider with ports CLK, RST, load, step, d_in[10:0], r_in[10:0], q[13:0], rem[11:0].
- fpdiv owns the FSM, iteration counter, prenormalize, and round/pack logic.

Test Plan:
- a=16'h4200 (3.0), b=16'h3E00 (1.5) → out=16'h4000, all flags 0. out_valid exactly 16 cycles after acceptance.
- a=16'h3C00 (1.0), b=16'h4200 (3.0) → out=16'h3555, flags 0. Then a=16'hBC00 with the same b → out=16'hB555.
- a=16'h4000, b=16'h0000 → out=16'h7FFF, overflow=1, div_zero=1. a=16'hC000, b=16'h8000 → out=16'h7FFF.
- a=16'h7BFF (65504), b=16'h3800 (0.5) → out=16'h7FFF, overflow=1. a=16'hFBFF with the same b → out=16'hFFFF.
- a=16'h0400 (2^-14), b=16'h4000 → out=16'h0200, sub=1. a=16'h0000, b=16'h4000 → out=16'h0000, sub=1.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles after out_valid → out stable, in_ready=0, and a new in_valid is ignored.
  - Assert RST for 1 cycle during DIVIDE → next cycle in_ready=1, out_valid=0, out=0.
